// File: rtl/frame_scanout_if.sv
// Frame read port and pixel output stream of the frame scanout engine.
interface frame_scanout_if #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int COLOR_WIDTH = 24
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic                   rd_en;
    logic [XW-1:0]          rd_x;
    logic [YW-1:0]          rd_y;
    logic [COLOR_WIDTH-1:0] canvas_rdata;
    logic [COLOR_WIDTH-1:0] cursor_rdata;

    logic                   pix_valid;
    logic                   pix_ready;
    logic [COLOR_WIDTH-1:0] pix_color;
    logic [XW-1:0]          pix_x;
    logic [YW-1:0]          pix_y;
    logic                   pix_sof;
    logic                   pix_eol;

    modport master (
        output rd_en, rd_x, rd_y,
        input  canvas_rdata, cursor_rdata,
        output pix_valid, pix_color, pix_x, pix_y, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  rd_en, rd_x, rd_y,
        output canvas_rdata, cursor_rdata,
        input  pix_valid, pix_color, pix_x, pix_y, pix_sof, pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/frame_scanout.sv
// Frame scanout: raster-order reads of canvas and cursor layers, composites
// them and streams the pixels through a 2-entry output FIFO.
module frame_scanout #(
    parameter int                     WIDTH       = 640,
    parameter int                     HEIGHT      = 480,
    parameter int                     COLOR_WIDTH = 24,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    frame_scanout_if.master  bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]             state_q;
    logic [XW-1:0]          rd_x_q;
    logic [YW-1:0]          rd_y_q;
    logic                   ifl_q;
    logic [XW-1:0]          ifl_x_q;
    logic [YW-1:0]          ifl_y_q;
    logic [1:0]             count_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [COLOR_WIDTH-1:0] mem_c [2];
    logic [XW-1:0]          mem_x [2];
    logic [YW-1:0]          mem_y [2];

    logic [COLOR_WIDTH-1:0] in_color;
    logic [COLOR_WIDTH-1:0] head_c;
    logic [XW-1:0]          head_x;
    logic [YW-1:0]          head_y;
    logic [2:0]             occ;
    logic                   from_mem;
    logic                   head_valid;
    logic                   pop;
    logic                   pop_mem;
    logic                   push;
    logic                   rd_go;
    logic                   last_rd;

    // Composite, select FIFO head and derive handshake/strobe outputs.
    // When the FIFO is empty the returning read is presented directly, so a
    // pixel is visible the cycle its data arrives and is only stored if it
    // is not accepted straight away.
    always_comb begin
        in_color   = (bus.cursor_rdata != COLOR_NONE) ? bus.cursor_rdata : bus.canvas_rdata;
        from_mem   = (count_q != 2'd0);
        head_valid = from_mem || ifl_q;
        head_c     = from_mem ? mem_c[rd_ptr_q] : in_color;
        head_x     = from_mem ? mem_x[rd_ptr_q] : ifl_x_q;
        head_y     = from_mem ? mem_y[rd_ptr_q] : ifl_y_q;
        occ        = {1'b0, count_q} + {2'b00, ifl_q};
        pop        = head_valid && bus.pix_ready;
        pop_mem    = pop && from_mem;
        push       = ifl_q && !(pop && !from_mem);
        rd_go      = (state_q == SCAN) && !abort && (occ < 3'd2);
        last_rd    = (rd_x_q == X_LAST) && (rd_y_q == Y_LAST);
        busy       = (state_q != IDLE);
        done       = (state_q == DRAIN) && !abort && pop && (head_x == X_LAST) && (head_y == Y_LAST);

        bus.rd_en     = rd_go;
        bus.rd_x      = rd_x_q;
        bus.rd_y      = rd_y_q;
        bus.pix_valid = head_valid;
        bus.pix_color = head_valid ? head_c : '0;
        bus.pix_x     = head_valid ? head_x : '0;
        bus.pix_y     = head_valid ? head_y : '0;
        bus.pix_sof   = head_valid && (head_x == '0) && (head_y == '0);
        bus.pix_eol   = head_valid && (head_x == X_LAST);
    end

    // FIFO storage for pixels that were not accepted on arrival.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_c[wr_ptr_q] <= in_color;
            mem_x[wr_ptr_q] <= ifl_x_q;
            mem_y[wr_ptr_q] <= ifl_y_q;
        end
    end

    // FSM, read coordinate counters, in-flight tracking and FIFO pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rd_x_q   <= '0;
            rd_y_q   <= '0;
            ifl_q    <= 1'b0;
            ifl_x_q  <= '0;
            ifl_y_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else if (busy && abort) begin
            state_q  <= IDLE;
            rd_x_q   <= '0;
            rd_y_q   <= '0;
            ifl_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (start) state_q <= SCAN;
                SCAN:    if (rd_go && last_rd) state_q <= DRAIN;
                DRAIN:   if (done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (state_q == IDLE && start) begin
                rd_x_q <= '0;
                rd_y_q <= '0;
            end else if (rd_go) begin
                if (rd_x_q == X_LAST) begin
                    rd_x_q <= '0;
                    rd_y_q <= (rd_y_q == Y_LAST) ? '0 : rd_y_q + 1'b1;
                end else begin
                    rd_x_q <= rd_x_q + 1'b1;
                end
            end
            ifl_q <= rd_go;
            if (rd_go) begin
                ifl_x_q <= rd_x_q;
                ifl_y_q <= rd_y_q;
            end
            if (push)    wr_ptr_q <= ~wr_ptr_q;
            if (pop_mem) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop_mem};
        end
    end
endmodule

// File: tb/tb_frame_scanout.sv
// Self-checking bench for frame_scanout (4x2 frame).
module tb_frame_scanout;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int CW = 24;
    localparam logic [CW-1:0] NONE   = '0;
    localparam logic [CW-1:0] BLUE   = 24'h0000FF;
    localparam logic [CW-1:0] CURSOR = 24'hFF0000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic abort   = 1'b0;
    logic busy;
    logic done;

    frame_scanout_if #(.WIDTH(W), .HEIGHT(H), .COLOR_WIDTH(CW)) bus();

    frame_scanout #(
        .WIDTH(W), .HEIGHT(H), .COLOR_WIDTH(CW), .COLOR_NONE(NONE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] canvas_mem [N];
    logic [CW-1:0] cursor_mem [N];

    // Frame memories: registered read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.canvas_rdata <= canvas_mem[int'(bus.rd_y) * W + int'(bus.rd_x)];
            bus.cursor_rdata <= cursor_mem[int'(bus.rd_y) * W + int'(bus.rd_x)];
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the cursor layer wins wherever it is not transparent.
    function automatic logic [CW-1:0] exp_color(input int i);
        return (cursor_mem[i] != NONE) ? cursor_mem[i] : canvas_mem[i];
    endfunction

    typedef struct {
        int          mode;          // 0 ready high, 1 toggle, 2 5-cycle stall, 3 random
        logic [N-1:0] cursor_mask;
        bit          blue_canvas;
        int          abort_after;   // -1: no abort
        bit          start_with_abort;
        int          exp_pops;
        bit          exp_done;
    } vec_t;

    vec_t vecs [10];

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_rd_xy"}, {bus.rd_x, bus.rd_y}, 0);
        check({tag, "_valid"}, bus.pix_valid, 0);
        check({tag, "_color"}, bus.pix_color, 0);
        check({tag, "_pxy"},   {bus.pix_x, bus.pix_y}, 0);
        check({tag, "_sofeol"}, {bus.pix_sof, bus.pix_eol}, 0);
    endtask

    task automatic run_frame(input vec_t v);
        int R = 0;
        int P = 0;
        int cyc = 0;
        int stall = 5;
        bit fin = 0;
        bit aborted = 0;
        bit pop;
        logic pv_prev = 0;
        logic pr_prev = 0;
        logic [CW-1:0] pc_prev = '0;
        logic [7:0] pxy_prev = '0;
        for (int i = 0; i < N; i++) begin
            canvas_mem[i] = v.blue_canvas ? BLUE : CW'($urandom);
            cursor_mem[i] = v.cursor_mask[i] ? (v.blue_canvas ? CURSOR : (CW'($urandom) | 24'h1)) : NONE;
        end
        @(posedge clk); #1;
        start = 1'b1;
        abort = v.start_with_abort;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        check("c0_busy", busy, 0);
        check("c0_rd_en", bus.rd_en, 0);
        while (!fin && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            start = (v.mode == 1 && cyc == 3);
            abort = 1'b0;
            case (v.mode)
                0: bus.pix_ready = 1'b1;
                1: bus.pix_ready = cyc[0];
                2: begin
                    if (P >= 2 && stall > 0) begin
                        bus.pix_ready = 1'b0;
                        stall--;
                    end else begin
                        bus.pix_ready = 1'b1;
                    end
                end
                default: bus.pix_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (v.abort_after >= 0 && P == v.abort_after) begin
                bus.pix_ready = 1'b0;
                abort = 1'b1;
            end
            @(negedge clk);
            if (abort) begin
                @(posedge clk); #1;
                abort = 1'b0;
                bus.pix_ready = 1'b1;
                @(negedge clk);
                check("abort_busy", busy, 0);
                check("abort_valid", bus.pix_valid, 0);
                check("abort_done", done, 0);
                fin = 1;
                aborted = 1;
            end else begin
                if (cyc == 1) begin
                    check("lat_rd_en", bus.rd_en, 1);
                    check("lat_valid_c1", bus.pix_valid, 0);
                end
                if (cyc == 2) check("lat_valid_c2", bus.pix_valid, 1);
                if (v.mode == 0 && cyc >= 2 && cyc <= N + 1) check("throughput", bus.pix_valid, 1);
                check("rd_credit", bus.rd_en && (R - P >= 2), 0);
                if (bus.rd_en) begin
                    check("rd_bound", R < N, 1);
                    check("rd_xy", {24'(bus.rd_x), 24'(bus.rd_y)}, {24'(R % W), 24'(R / W)});
                    R++;
                end
                if (pv_prev && !pr_prev) begin
                    check("stall_hold", {bus.pix_valid, bus.pix_color, 8'({bus.pix_x, bus.pix_y})},
                          {1'b1, pc_prev, pxy_prev});
                end
                pop = bus.pix_valid && bus.pix_ready;
                if (pop) begin
                    check("pix_color", bus.pix_color, exp_color(P));
                    check("pix_xy", {24'(bus.pix_x), 24'(bus.pix_y)}, {24'(P % W), 24'(P / W)});
                    check("sof_eol", {bus.pix_sof, bus.pix_eol}, {P == 0, (P % W) == W - 1});
                    P++;
                end
                check("done", done, pop && P == N);
                if (pop && P == N) fin = 1;
                pv_prev  = bus.pix_valid;
                pr_prev  = bus.pix_ready;
                pc_prev  = bus.pix_color;
                pxy_prev = 8'({bus.pix_x, bus.pix_y});
            end
        end
        check("frame_finished", fin, 1);
        check("pop_count", P, v.exp_pops);
        if (!aborted && fin) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("post_busy", busy, 0);
            check("post_valid", bus.pix_valid, 0);
        end
        check("aborted", aborted, !v.exp_done);
    endtask

    initial begin
        bus.pix_ready = 1'b1;
        #1;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // abort alone in IDLE does nothing
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_rd_en", bus.rd_en, 0);

        vecs[0] = '{mode: 0, cursor_mask: 8'h00, blue_canvas: 1, abort_after: -1, start_with_abort: 0, exp_pops: 8, exp_done: 1};
        vecs[1] = '{mode: 0, cursor_mask: 8'h66, blue_canvas: 1, abort_after: -1, start_with_abort: 0, exp_pops: 8, exp_done: 1};
        vecs[2] = '{mode: 2, cursor_mask: 8'h66, blue_canvas: 0, abort_after: -1, start_with_abort: 0, exp_pops: 8, exp_done: 1};
        vecs[3] = '{mode: 1, cursor_mask: 8'h00, blue_canvas: 0, abort_after: -1, start_with_abort: 0, exp_pops: 8, exp_done: 1};
        vecs[4] = '{mode: 0, cursor_mask: 8'h00, blue_canvas: 1, abort_after: 3,  start_with_abort: 0, exp_pops: 3, exp_done: 0};
        vecs[5] = '{mode: 0, cursor_mask: 8'h81, blue_canvas: 0, abort_after: -1, start_with_abort: 1, exp_pops: 8, exp_done: 1};
        for (int i = 6; i < 10; i++) begin
            vecs[i] = '{mode: 3, cursor_mask: N'($urandom), blue_canvas: 0,
                        abort_after: (i == 9) ? 5 : -1, start_with_abort: 0,
                        exp_pops: (i == 9) ? 5 : 8, exp_done: (i != 9)};
        end
        for (int i = 0; i < 10; i++) run_frame(vecs[i]);

        // asynchronous reset mid-frame, start ignored while held
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", busy, 0);
        check("rst_start_rd_en", bus.rd_en, 0);
        #2;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_frame(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/frame_scanout.md
FRAME_SCANOUT -- requirements
Module: frame_scanout

Interface
REQ-001 Parameter WIDTH, default 640: frame width in pixels.
REQ-002 Parameter HEIGHT, default 480: frame height in pixels.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse requesting one full-frame scan.
REQ-006 abort  input  1  synchronous request to cancel the scan in progress.
REQ-007 rd_en  output  1  read strobe shared by the canvas and cursor frame read ports.
REQ-008 rd_x  output  $clog2(WIDTH)  read column.
REQ-009 rd_y  output  $clog2(HEIGHT)  read row.
REQ-010 canvas_rdata  input  COLOR_WIDTH  canvas colour at (rd_x, rd_y); valid the cycle after rd_en.
REQ-011 cursor_rdata  input  COLOR_WIDTH  cursor-layer colour at (rd_x, rd_y); valid the cycle after rd_en.
REQ-012 pix_valid  output  1  an output pixel is presented.
REQ-013 pix_ready  input  1  the downstream consumer accepts the pixel.
REQ-014 pix_color  output  COLOR_WIDTH  composited pixel colour.
REQ-015 pix_x / pix_y  output  $clog2(WIDTH) / $clog2(HEIGHT)  coordinates of the presented pixel.
REQ-016 pix_sof  output  1  high with the pixel at (0,0).
REQ-017 pix_eol  output  1  high with every pixel where x == WIDTH-1.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse when the final pixel of a frame is accepted.

Function
REQ-020 The FSM SHALL have the states IDLE, SCAN and DRAIN.
REQ-021 IDLE -> SCAN SHALL occur on start; read coordinates initialise to (0,0); start SHALL be ignored outside IDLE.
REQ-022 Reads SHALL be issued in raster order, x fastest; after x == WIDTH-1, x wraps to 0 and y increments.
REQ-023 The block SHALL hold a 2-entry output FIFO (colour, x, y); rd_en SHALL assert only when FIFO occupancy + in-flight reads < 2, so the FIFO never overflows.
REQ-024 Compositing SHALL be: pix_color = cursor_rdata when cursor_rdata != COLOR_NONE, else canvas_rdata; the result is pushed the cycle after rd_en.
REQ-025 The head of the FIFO SHALL drive the pix_* outputs; a pop occurs when pix_valid && pix_ready.
REQ-026 While pix_valid is high and pix_ready is low, pix_* SHALL hold stable.
REQ-027 Latency: the first rd_en SHALL occur the cycle after start, and the first pix_valid 2 cycles after start.
REQ-028 Throughput SHALL be 1 pixel/cycle with pix_ready held high.
REQ-029 SCAN -> DRAIN SHALL occur on the cycle the read for (WIDTH-1, HEIGHT-1) is issued.
REQ-030 DRAIN -> IDLE SHALL occur when the FIFO is empty and no read is in flight; done SHALL pulse on the cycle the final pixel pops.
REQ-031 A simultaneous push and pop SHALL leave occupancy unchanged; a push into a full FIFO is structurally impossible per REQ-023.
REQ-032 abort in SCAN or DRAIN SHALL return the FSM to IDLE on the next edge: FIFO flushed, in-flight data discarded, pix_valid low, no done pulse.
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 abort and start in the same IDLE cycle SHALL result in start taking effect.
REQ-035 Coordinate counters SHALL never exceed WIDTH-1 / HEIGHT-1.

Reset
REQ-036 While reset_n is low, the block SHALL be in IDLE with FIFO empty, in-flight cleared, and rd_en, rd_x, rd_y, pix_valid, pix_color, pix_x, pix_y, pix_sof, pix_eol, busy, done all 0.
REQ-037 Assertion of reset_n mid-frame SHALL take effect immediately, without waiting for clk; after release, the block waits for a new start.

Verification (WIDTH=4, HEIGHT=2)
REQ-038 Canvas all COLOR_BLUE, cursor all COLOR_NONE, pix_ready=1, start -> 8 pixels on consecutive cycles from cycle 2: (0,0)..(3,1) all BLUE; sof on pixel 0; eol on pixels 3 and 7; done with pixel 7; busy low the next cycle.
REQ-039 Cursor non-NONE only at (1,0),(2,0),(1,1),(2,1) -> exactly those 4 pixels carry the cursor colour; the rest are canvas colour.
REQ-040 pix_ready low for 5 cycles mid-frame -> pix_* stable during the stall, rd_en low once occupancy + in-flight == 2, no pixel lost or duplicated, order preserved.
REQ-041 pix_ready toggling every cycle -> exactly 8 pops in raster order; done on the 8th pop.
REQ-042 abort after 3 pixels accepted -> next cycle busy=0, pix_valid=0, no done; a fresh start rescans from (0,0).
REQ-043 reset_n low between clock edges mid-frame -> all outputs 0 immediately; start is ignored until reset_n is high.
